// File: rtl/mux_rr_nto1.sv
// N-input registered multiplexer with valid/ready handshaking on every port.
// Passes a fixed channel (select mode) or arbitrates round-robin (arbiter mode).
module mux_rr_nto1 #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] r_outData;
  logic [SELW-1:0]  r_outSrc;
  logic             r_outValid;
  logic [SELW-1:0]  r_last;

  logic             w_load;
  logic             w_selV;
  logic             w_arbV;
  logic [SELW-1:0]  w_arbGnt;
  logic             w_gntV;
  logic [SELW-1:0]  w_gnt;
  logic             w_accept;
  logic [WIDTH-1:0] w_gntData;
  int               w_rrIdx;

  // Scan from the lowest priority (last) down to last+1 so the nearest valid channel past last wins.
  always_comb begin
    w_arbV   = 1'b0;
    w_arbGnt = '0;
    w_rrIdx  = 0;
    for (int k = N; k >= 1; k--) begin
      w_rrIdx = (int'(r_last) + k) % N;
      if (in_valid[SELW'(w_rrIdx)]) begin
        w_arbV   = 1'b1;
        w_arbGnt = SELW'(w_rrIdx);
      end
    end
  end

  assign w_selV   = (int'(sel) < N) && in_valid[sel];
  assign w_gntV   = mode ? w_arbV : w_selV;
  assign w_gnt    = mode ? w_arbGnt : sel;
  assign w_load   = !r_outValid || out_ready;
  assign w_accept = rst_n && w_gntV && w_load;

  always_comb begin
    in_ready = '0;
    if (w_accept) begin
      in_ready[w_gnt] = 1'b1;
    end
  end

  always_comb begin
    w_gntData = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == SELW'(i)) begin
        w_gntData = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // A load with nothing granted empties the register but keeps the stale word and source.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outData  <= '0;
      r_outSrc   <= '0;
      r_outValid <= 1'b0;
      r_last     <= SELW'(N - 1);
    end else if (w_load) begin
      if (w_gntV) begin
        r_outData  <= w_gntData;
        r_outSrc   <= w_gnt;
        r_outValid <= 1'b1;
        r_last     <= w_gnt;
      end else begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign out_data  = r_outData;
  assign out_src   = r_outSrc;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Directed bench for mux_rr_nto1: per-cycle vectors push expected words into a
// scoreboard that a separate monitor drains on every output transfer.
module tb_mux_rr_nto1;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N*WIDTH-1:0] in_data = '0;
  logic [N-1:0]       in_valid = '0;
  logic [N-1:0]       in_ready;
  logic               mode = 1'b1;
  logic [SELW-1:0]    sel = '0;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_src;
  logic               out_valid;
  logic               out_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int midReset;

  typedef struct packed {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic        oready;
    logic [31:0] data;
    logic [3:0]  expRdy;
    logic        expOv;
    logic        chkHold;
    logic [7:0]  holdData;
  } stepT;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
  } expT;

  stepT steps[$];
  expT  sbQ[$];
  expT  mExp;

  mux_rr_nto1 #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void addStep(input logic m, input logic [1:0] s, input logic [3:0] v,
                                  input logic o, input logic [31:0] d, input logic [3:0] r,
                                  input logic ov, input logic h, input logic [7:0] hd);
    stepT st;
    st = '{mode: m, sel: s, valid: v, oready: o, data: d, expRdy: r,
           expOv: ov, chkHold: h, holdData: hd};
    steps.push_back(st);
  endfunction

  // Inputs change 1 time unit after the rising edge; combinational and register outputs are checked 1 unit later.
  task automatic applyStimulus(input stepT s);
    expT e;
    int  ch;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mode      = s.mode;
    sel       = s.sel;
    in_valid  = s.valid;
    out_ready = s.oready;
    in_data   = s.data;
    #1;
    checkOutput("in_ready", 32'(in_ready), 32'(s.expRdy));
    checkOutput("out_valid", 32'(out_valid), 32'(s.expOv));
    if (s.chkHold) begin
      checkOutput("hold_data", 32'(out_data), 32'(s.holdData));
      checkOutput("hold_src", 32'(out_src), 32'd0);
    end
    if (s.expRdy != 4'b0000) begin
      ch = 0;
      for (int i = 0; i < N; i++) begin
        if (s.expRdy[i]) ch = i;
      end
      e.src  = 2'(ch);
      e.data = 8'(s.data >> (8 * ch));
      sbQ.push_back(e);
    end
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    mode      = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b0;
    in_data   = 32'h13121110;
    sbQ.delete();
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_out_src", 32'(out_src), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    end
  endtask

  // Monitor: a transfer happens on the coming rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got src %0d data 0x%0h, expected no word", out_src, out_data);
      end else begin
        mExp = sbQ.pop_front();
        checkOutput("out_src", 32'(out_src), 32'(mExp.src));
        checkOutput("out_data", 32'(out_data), 32'(mExp.data));
      end
    end
  end

  initial begin
    // Fairness: all valid, grants 0..3 twice starting at channel 0 after reset.
    addStep(1, 0, 4'hF, 1, 32'h13121110, 4'b0001, 0, 0, 8'h00);
    addStep(1, 0, 4'hF, 1, 32'h13121110, 4'b0010, 1, 0, 8'h00);
    addStep(1, 0, 4'hF, 1, 32'h13121110, 4'b0100, 1, 0, 8'h00);
    addStep(1, 0, 4'hF, 1, 32'h13121110, 4'b1000, 1, 0, 8'h00);
    addStep(1, 0, 4'hF, 1, 32'h13121110, 4'b0001, 1, 0, 8'h00);
    addStep(1, 0, 4'hF, 1, 32'h13121110, 4'b0010, 1, 0, 8'h00);
    addStep(1, 0, 4'hF, 1, 32'h13121110, 4'b0100, 1, 0, 8'h00);
    addStep(1, 0, 4'hF, 1, 32'h13121110, 4'b1000, 1, 0, 8'h00);
    // Skip: channels 1 and 3 alternate, then channel 1 alone.
    addStep(1, 0, 4'hA, 1, 32'h13121110, 4'b0010, 1, 0, 8'h00);
    addStep(1, 0, 4'hA, 1, 32'h13121110, 4'b1000, 1, 0, 8'h00);
    addStep(1, 0, 4'hA, 1, 32'h13121110, 4'b0010, 1, 0, 8'h00);
    addStep(1, 0, 4'hA, 1, 32'h13121110, 4'b1000, 1, 0, 8'h00);
    addStep(1, 0, 4'h2, 1, 32'h13121110, 4'b0010, 1, 0, 8'h00);
    addStep(1, 0, 4'h2, 1, 32'h13121110, 4'b0010, 1, 0, 8'h00);
    // Select mode: channel 2 carries 0xA5, then sel=1 with channel 1 idle.
    addStep(0, 2, 4'h4, 1, 32'h13A51110, 4'b0100, 1, 0, 8'h00);
    addStep(0, 1, 4'h4, 1, 32'h13A51110, 4'b0000, 1, 0, 8'h00);
    addStep(0, 1, 4'h0, 1, 32'h13A51110, 4'b0000, 0, 0, 8'h00);
    // Back to arbiter mode: last served was 2, so channel 3 is next.
    addStep(1, 0, 4'hF, 1, 32'h13121110, 4'b1000, 0, 0, 8'h00);
    // Back-pressure: hold 0x42 three cycles, then drain and fill 0x55 together.
    addStep(0, 0, 4'h1, 1, 32'h13121142, 4'b0001, 1, 0, 8'h00);
    addStep(0, 0, 4'h1, 0, 32'h13121155, 4'b0000, 1, 1, 8'h42);
    addStep(0, 0, 4'h1, 0, 32'h13121155, 4'b0000, 1, 1, 8'h42);
    addStep(0, 0, 4'h1, 0, 32'h13121155, 4'b0000, 1, 1, 8'h42);
    addStep(0, 0, 4'h1, 1, 32'h13121155, 4'b0001, 1, 0, 8'h00);
    addStep(1, 0, 4'h0, 1, 32'h13121110, 4'b0000, 1, 0, 8'h00);
    // Load a word and stall it, then reset discards it.
    addStep(1, 0, 4'h1, 0, 32'h13121110, 4'b0001, 0, 0, 8'h00);
    addStep(1, 0, 4'h1, 0, 32'h13121110, 4'b0000, 1, 1, 8'h10);
    midReset = steps.size();
    addStep(1, 0, 4'hF, 1, 32'h13121110, 4'b0001, 0, 0, 8'h00);
    addStep(1, 0, 4'h0, 1, 32'h13121110, 4'b0000, 1, 0, 8'h00);

    resetDut();
    for (int i = 0; i < steps.size(); i++) begin
      if (i == midReset) resetDut();
      applyStimulus(steps[i]);
    end

    @(posedge clk);
    #1;
    checkOutput("final_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
